// File: rtl/uart_flit_assembler.sv
// -----------------------------------------------------------------------------
// uart_flit_assembler
//
// Byte-to-flit deframer that sits directly after uart_rx. It hunts for a
// start-of-flit byte, collects NBYTES payload bytes, checks an XOR checksum
// byte, and then holds the assembled flit on a valid/ready interface until
// the packet layer takes it. Checksum, timeout, line-error and overflow
// events are reported, and a saturating count of all of them is kept.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   rx_data[7:0]  in   byte from uart_rx
//   rx_valid      in   one-cycle strobe qualifying rx_data
//   rx_err        in   framing/parity error for the strobed byte
//   flit_o        out  assembled flit, payload byte k at bits [8k+7:8k]
//   flit_valid_o  out  flit_o holds a checked flit
//   flit_ready_i  in   consumer accepts when flit_valid_o && flit_ready_i
//   crc_err_o     out  one-cycle pulse on checksum mismatch
//   timeout_o     out  one-cycle pulse on inter-byte timeout
//   drop_o        out  one-cycle pulse when a byte is discarded while a
//                      flit is pending
//   err_count_o   out  saturating count of all error events
// -----------------------------------------------------------------------------
module uart_flit_assembler #(
  parameter int          FLIT_WIDTH     = 64,
  parameter logic [7:0]  SOF_BYTE       = 8'h7E,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  flit_valid_o,
  input  logic                  flit_ready_i,
  output logic                  crc_err_o,
  output logic                  timeout_o,
  output logic                  drop_o,
  output logic [7:0]            err_count_o
);

  localparam int NBYTES = FLIT_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  // The timeout pulse is registered, so it is launched on the edge where the
  // timer steps onto TIMEOUT_CYCLES-1; that makes it visible in the same
  // cycle the timer reaches its limit.
  localparam logic [TMR_W-1:0] TMR_FIRE = TMR_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAYLOAD  = 2'd1,
    S_CHECKSUM = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_acc;
  logic [TMR_W-1:0]      r_timer;
  logic [FLIT_WIDTH-1:0] r_flit;
  logic                  r_flit_valid;
  logic                  r_crc_err;
  logic                  r_timeout;
  logic                  r_drop;
  logic [7:0]            r_err_count;

  logic w_accept;
  logic w_line_err;
  logic w_sof;
  logic w_in_frame;
  logic w_crc_evt;
  logic w_abort_evt;
  logic w_tmo_evt;
  logic w_drop_evt;
  logic w_err_evt;

  assign w_accept   = rx_valid & ~rx_err;
  assign w_line_err = rx_valid & rx_err;
  assign w_sof      = w_accept & (rx_data == SOF_BYTE);
  assign w_in_frame = (r_state == S_PAYLOAD) | (r_state == S_CHECKSUM);

  // Event decode. The conditions are mutually exclusive, so at most one
  // error event can occur per cycle. A strobe of any kind on the firing
  // cycle suppresses the timeout: a good byte restarts the timer and a bad
  // one is reported as a line-error abort instead.
  assign w_crc_evt   = (r_state == S_CHECKSUM) & w_accept & (rx_data != r_acc);
  assign w_abort_evt = w_in_frame & w_line_err;
  assign w_tmo_evt   = w_in_frame & ~rx_valid & (r_timer == TMR_FIRE);
  assign w_drop_evt  = (r_state == S_HOLD) & ~flit_ready_i & rx_valid;
  assign w_err_evt   = w_crc_evt | w_abort_evt | w_tmo_evt | w_drop_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_timer      <= '0;
      r_flit       <= '0;
      r_flit_valid <= 1'b0;
      r_crc_err    <= 1'b0;
      r_timeout    <= 1'b0;
      r_drop       <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_crc_err <= w_crc_evt;
      r_timeout <= w_tmo_evt;
      r_drop    <= w_drop_evt;

      if (w_err_evt && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_sof) begin
            r_state <= S_PAYLOAD;
            r_idx   <= '0;
            r_acc   <= '0;
            r_timer <= '0;
          end
        end

        S_PAYLOAD: begin
          if (w_line_err) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            // SOF_BYTE is ordinary data here.
            r_flit[8*r_idx +: 8] <= rx_data;
            r_acc                <= r_acc ^ rx_data;
            r_idx                <= r_idx + IDX_W'(1);
            r_timer              <= '0;
            if (r_idx == LAST_IDX) begin
              r_state <= S_CHECKSUM;
            end
          end else if (w_tmo_evt) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_CHECKSUM: begin
          if (w_line_err) begin
            r_state <= S_IDLE;
          end else if (w_accept) begin
            r_timer <= '0;
            if (rx_data == r_acc) begin
              r_state      <= S_HOLD;
              r_flit_valid <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_tmo_evt) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        S_HOLD: begin
          // On the handshake cycle the incoming byte is treated as if we
          // were already idle, so back-to-back frames lose no SOF.
          if (flit_ready_i) begin
            r_flit_valid <= 1'b0;
            if (w_sof) begin
              r_state <= S_PAYLOAD;
              r_idx   <= '0;
              r_acc   <= '0;
              r_timer <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign flit_o       = r_flit;
  assign flit_valid_o = r_flit_valid;
  assign crc_err_o    = r_crc_err;
  assign timeout_o    = r_timeout;
  assign drop_o       = r_drop;
  assign err_count_o  = r_err_count;

endmodule

// File: tb/tb_uart_flit_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_flit_assembler
//
// Directed bench for uart_flit_assembler (64-bit flits, 16-cycle timeout).
// Good frames push their expected flit into a queue when the checksum byte
// is driven; a monitor pops and compares on every handshake. Pulses, error
// counts and timing are checked inline after each step.
// -----------------------------------------------------------------------------
module tb_uart_flit_assembler;

  localparam int FW = 64;

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic [FW-1:0] flit_o;
  logic          flit_valid_o;
  logic          flit_ready_i;
  logic          crc_err_o;
  logic          timeout_o;
  logic          drop_o;
  logic [7:0]    err_count_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] q_exp[$];

  uart_flit_assembler #(
    .FLIT_WIDTH    (FW),
    .SOF_BYTE      (8'h7E),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .flit_o      (flit_o),
    .flit_valid_o(flit_valid_o),
    .flit_ready_i(flit_ready_i),
    .crc_err_o   (crc_err_o),
    .timeout_o   (timeout_o),
    .drop_o      (drop_o),
    .err_count_o (err_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    rx_data  = b;
    rx_valid = 1'b1;
    rx_err   = e;
    step();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  // Payload bytes followed by the checksum; a bad checksum is the correct
  // one with bit 0 flipped.
  task automatic send_body(input logic [63:0] p, input logic good);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 8; k++) begin
      send_byte(p[8*k +: 8], 1'b0);
      c = c ^ p[8*k +: 8];
    end
    if (good) begin
      q_exp.push_back(p);
      send_byte(c, 1'b0);
    end else begin
      send_byte(c ^ 8'h01, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [63:0] p, input logic good);
    send_byte(8'h7E, 1'b0);
    send_body(p, good);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, before the edge that
  // completes them.
  always @(negedge clk) begin
    if (rst_n && flit_valid_o && flit_ready_i) begin
      check("sb_nonempty", 64'(q_exp.size() > 0), 64'd1);
      if (q_exp.size() > 0) begin
        check("sb_flit", flit_o, q_exp.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] nom [9];
    nom = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    rst_n        = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    rx_err       = 1'b0;
    flit_ready_i = 1'b0;
    step();
    step();

    // Reset state
    check("rst_flit",  flit_o,       64'd0);
    check("rst_valid", flit_valid_o, 64'd0);
    check("rst_cnt",   err_count_o,  64'd0);
    check("rst_crc",   crc_err_o,    64'd0);
    check("rst_tmo",   timeout_o,    64'd0);
    check("rst_drop",  drop_o,       64'd0);
    rst_n = 1'b1;
    step();

    // Nominal frame with exact one-cycle latency
    flit_ready_i = 1'b1;
    foreach (nom[i]) send_byte(nom[i], 1'b0);
    check("nom_valid_before", flit_valid_o, 64'd0);
    q_exp.push_back(64'h0807060504030201);
    send_byte(8'h08, 1'b0);
    check("nom_valid",  flit_valid_o, 64'd1);
    check("nom_flit",   flit_o,       64'h0807060504030201);
    check("nom_crc",    crc_err_o,    64'd0);
    check("nom_tmo",    timeout_o,    64'd0);
    check("nom_drop",   drop_o,       64'd0);
    step();
    check("nom_valid_after", flit_valid_o, 64'd0);
    check("nom_cnt", err_count_o, 64'd0);

    // Bad checksum (09), then a good frame
    send_frame(64'h0807060504030201, 1'b0);
    check("crc_pulse", crc_err_o,    64'd1);
    check("crc_valid", flit_valid_o, 64'd0);
    check("crc_cnt",   err_count_o,  64'd1);
    step();
    check("crc_pulse_end", crc_err_o,    64'd0);
    check("crc_valid_end", flit_valid_o, 64'd0);
    send_frame(64'h1122334455667788, 1'b1);
    check("crc_next_valid", flit_valid_o, 64'd1);
    check("crc_next_flit",  flit_o,       64'h1122334455667788);
    step();

    // Backpressure and drop
    do_reset();
    flit_ready_i = 1'b0;
    send_frame(64'hA1B2C3D4E5F60718, 1'b1);
    check("bp_valid", flit_valid_o, 64'd1);
    step();
    step();
    check("bp_hold", flit_valid_o, 64'd1);
    send_byte(8'hAA, 1'b0);
    check("bp_drop1", drop_o,      64'd1);
    check("bp_cnt1",  err_count_o, 64'd1);
    send_byte(8'hBB, 1'b0);
    check("bp_drop2", drop_o,      64'd1);
    check("bp_cnt2",  err_count_o, 64'd2);
    check("bp_flit",  flit_o,      64'hA1B2C3D4E5F60718);
    check("bp_valid2", flit_valid_o, 64'd1);
    flit_ready_i = 1'b1;
    send_byte(8'h7E, 1'b0);
    check("bp_hs_valid", flit_valid_o, 64'd0);
    check("bp_hs_drop",  drop_o,       64'd0);
    send_body(64'h0F1E2D3C4B5A6978, 1'b1);
    check("bp_next_valid", flit_valid_o, 64'd1);
    check("bp_next_flit",  flit_o,       64'h0F1E2D3C4B5A6978);
    check("bp_next_cnt",   err_count_o,  64'd2);
    step();

    // Inter-byte timeout
    do_reset();
    send_byte(8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int c = 1; c < 15; c++) begin
      step();
      check("tmo_early", timeout_o, 64'd0);
    end
    step();
    check("tmo_pulse", timeout_o,   64'd1);
    check("tmo_cnt",   err_count_o, 64'd1);
    step();
    check("tmo_pulse_end", timeout_o, 64'd0);
    for (int c = 0; c < 4; c++) step();
    check("tmo_no_repeat", timeout_o, 64'd0);
    send_frame(64'h8877665544332211, 1'b1);
    check("tmo_next_valid", flit_valid_o, 64'd1);
    check("tmo_next_flit",  flit_o,       64'h8877665544332211);
    step();

    // Hunting, line-error abort, SOF as payload
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h7E, 1'b1);
    check("hunt_cnt", err_count_o, 64'd0);
    send_byte(8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    check("lerr_cnt",   err_count_o,  64'd1);
    check("lerr_crc",   crc_err_o,    64'd0);
    check("lerr_tmo",   timeout_o,    64'd0);
    check("lerr_drop",  drop_o,       64'd0);
    check("lerr_valid", flit_valid_o, 64'd0);
    // Remaining bytes of the aborted frame must not form a flit
    for (int k = 5; k < 10; k++) send_byte(8'(k), 1'b0);
    check("lerr_no_flit", flit_valid_o, 64'd0);
    send_frame(64'h000000000000007E, 1'b1);
    check("sofdata_valid", flit_valid_o, 64'd1);
    check("sofdata_flit",  flit_o,       64'h000000000000007E);
    step();

    // Error-count saturation
    do_reset();
    for (int n = 0; n < 260; n++) begin
      send_frame(64'd0, 1'b0);
      if (n == 254) check("sat_255", err_count_o, 64'd255);
    end
    check("sat_cnt", err_count_o, 64'd255);
    check("sat_crc", crc_err_o,   64'd1);

    // Asynchronous reset mid-payload
    send_byte(8'h7E, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flit",  flit_o,       64'd0);
    check("arst_valid", flit_valid_o, 64'd0);
    check("arst_cnt",   err_count_o,  64'd0);
    check("arst_crc",   crc_err_o,    64'd0);
    step();
    rst_n = 1'b1;
    step();
    send_frame(64'hDEADBEEFCAFEF00D, 1'b1);
    check("arst_next_valid", flit_valid_o, 64'd1);
    check("arst_next_flit",  flit_o,       64'hDEADBEEFCAFEF00D);
    step();
    step();

    check("sb_drained", 64'(q_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
